// File: rtl/ahb_arbiter_if.sv
// Arbitration signal bundle for the three-master system bus.
// The master modport is the arbiter's view; slave is the bus side.
interface ahb_arbiter_if;
    logic [2:0] HBUSREQ;
    logic [2:0] HLOCK;
    logic [1:0] HTRANS;
    logic       HREADY;
    logic [1:0] HRESP;
    logic [2:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    modport master (
        input  HBUSREQ, HLOCK, HTRANS, HREADY, HRESP,
        output HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        output HBUSREQ, HLOCK, HTRANS, HREADY, HRESP,
        input  HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin arbiter for three bus masters with lock hold,
// burst-length limit and RETRY-forced re-arbitration.
module ahb_arbiter #(
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_BURST      = 16
) (
    input  logic          CLK,
    input  logic          RST,
    ahb_arbiter_if.master bus
);
    typedef enum logic [1:0] {PARK, BUS, LOCK} state_t;

    localparam logic [1:0] DEF  = 2'(DEFAULT_MASTER);
    localparam logic [6:0] LAST = 7'(MAX_BURST - 1);
    localparam logic [6:0] SAT  = 7'd127;

    state_t     state, state_nx;
    logic [1:0] g, g_nx, p1, p2, win;
    logic [6:0] bc, bc_nx;
    logic [1:0] master_q;
    logic       mlock_q;
    logic       beat, held, retry, rearb;
    logic       any_req, lock_nx;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign p1    = inc3(g);
    assign p2    = inc3(p1);
    assign beat  = bus.HREADY & (bus.HTRANS inside {2'b10, 2'b11});
    assign held  = bus.HLOCK[g] & bus.HBUSREQ[g];
    assign retry = (bus.HRESP == 2'b10);

    // Current owner is scanned last so it has the lowest priority.
    always_comb begin
        win = DEF;
        if (bus.HBUSREQ[p1])     win = p1;
        else if (bus.HBUSREQ[p2]) win = p2;
        else if (bus.HBUSREQ[g])  win = g;
    end

    assign rearb = !bus.HBUSREQ[g] |
                   (!held & ((beat & (bc == LAST)) | retry));

    always_comb begin
        g_nx  = g;
        bc_nx = bc;
        if (bus.HREADY) begin
            if (rearb) begin
                g_nx  = win;
                bc_nx = '0;
            end else if (beat && bc != SAT) begin
                bc_nx = bc + 7'd1;
            end
        end
    end

    assign any_req = |bus.HBUSREQ;
    assign lock_nx = bus.HLOCK[g_nx] & bus.HBUSREQ[g_nx];

    always_comb begin
        state_nx = state;
        if (bus.HREADY) begin
            unique case (state)
                PARK: if (any_req) state_nx = lock_nx ? LOCK : BUS;
                BUS, LOCK: begin
                    if (!any_req)     state_nx = PARK;
                    else if (lock_nx) state_nx = LOCK;
                    else              state_nx = BUS;
                end
                default: state_nx = PARK;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= PARK;
            g        <= DEF;
            bc       <= '0;
            master_q <= DEF;
            mlock_q  <= 1'b0;
        end else begin
            state <= state_nx;
            g     <= g_nx;
            bc    <= bc_nx;
            // Address-phase outputs follow the grant by one ready edge.
            if (bus.HREADY) begin
                master_q <= g;
                mlock_q  <= held;
            end
        end
    end

    assign bus.HGRANT    = 3'b001 << g;
    assign bus.HMASTER   = master_q;
    assign bus.HMASTLOCK = mlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Randomized self-checking bench for ahb_arbiter against a
// cycle-level reference model of the arbitration rules.
module tb_ahb_arbiter;
    localparam int DEF  = 2;
    localparam int MAXB = 4;

    logic clk, rst;
    ahb_arbiter_if bus ();

    ahb_arbiter #(.DEFAULT_MASTER(DEF), .MAX_BURST(MAXB)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int nchk  = 0;
    int nfail = 0;

    int mg, mbc, mmaster;
    bit mlock;
    logic [5:0] expv, obs;

    assign obs = {bus.HGRANT, bus.HMASTER, bus.HMASTLOCK};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] pack_exp();
        logic [2:0] gr;
        gr = 3'b000;
        gr[mg] = 1'b1;
        return {gr, 2'(mmaster), mlock};
    endfunction

    task automatic model_reset();
        mg = DEF; mbc = 0; mmaster = DEF; mlock = 0;
        expv = pack_exp();
    endtask

    // Advance the model using the inputs present before the edge.
    task automatic tick();
        int  win, idx;
        bit  found, beat, held, rearb;
        if (bus.HREADY === 1'b1) begin
            beat  = bus.HTRANS[1];
            held  = bus.HLOCK[mg] && bus.HBUSREQ[mg];
            rearb = !bus.HBUSREQ[mg] ||
                    (!held && ((beat && mbc == MAXB - 1) ||
                               bus.HRESP == 2'b10));
            win = DEF; found = 0;
            for (int k = 1; k <= 3; k++) begin
                idx = (mg + k) % 3;
                if (!found && bus.HBUSREQ[idx]) begin
                    win = idx; found = 1;
                end
            end
            mmaster = mg;
            mlock   = held;
            if (rearb) begin
                mg = win; mbc = 0;
            end else if (beat && mbc < 127) begin
                mbc++;
            end
        end
        @(posedge clk);
        #1;
        expv = pack_exp();
    endtask

    task automatic idle_inputs();
        bus.HBUSREQ = 3'b000; bus.HLOCK = 3'b000;
        bus.HTRANS = 2'b00; bus.HREADY = 1'b1; bus.HRESP = 2'b00;
    endtask

    task automatic grant_to(input int i);
        idle_inputs();
        bus.HBUSREQ = 3'(1 << i);
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        nchk++;
        if (obs !== 6'b100_10_0) begin
            nfail++;
            $display("FAIL reset: got %b want %b", obs, 6'b100_10_0);
        end
        rst = 0;
    endtask

    task automatic test_park_grant();
        idle_inputs();
        bus.HBUSREQ = 3'b010;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) bus.HBUSREQ = 3'b000;
            tick();
            nchk++;
            if (obs !== expv) begin
                nfail++;
                $display("FAIL park_grant step %0d: got %b want %b", k, obs, expv);
            end
        end
        nchk++;
        if (bus.HGRANT !== 3'b100) begin
            nfail++;
            $display("FAIL park_return: got %b want 100", bus.HGRANT);
        end
    endtask

    task automatic test_burst();
        int tenure = 0;
        idle_inputs();
        bus.HBUSREQ = 3'b111;
        bus.HTRANS  = 2'b11;
        for (int k = 0; k < 24; k++) begin
            tick();
            nchk++;
            if (obs !== expv) begin
                nfail++;
                $display("FAIL burst cyc %0d: got %b want %b", k, obs, expv);
            end
        end
    endtask

    task automatic test_lock();
        grant_to(0);
        bus.HBUSREQ = 3'b011;
        bus.HLOCK   = 3'b001;
        bus.HTRANS  = 2'b11;
        for (int k = 0; k < 20; k++) begin
            tick();
            nchk++;
            if (obs !== expv || bus.HGRANT !== 3'b001) begin
                nfail++;
                $display("FAIL lock_hold cyc %0d: got %b want %b", k, obs, expv);
            end
        end
        nchk++;
        if (bus.HMASTLOCK !== 1'b1) begin
            nfail++;
            $display("FAIL lock_mastlock: got %b want 1", bus.HMASTLOCK);
        end
        bus.HLOCK = 3'b000;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) bus.HRESP = 2'b10;
            if (k == 4) bus.HRESP = 2'b00;
            tick();
            nchk++;
            if (obs !== expv) begin
                nfail++;
                $display("FAIL lock_release cyc %0d: got %b want %b", k, obs, expv);
            end
        end
    endtask

    task automatic test_wait_states();
        logic [5:0] frozen;
        bus.HTRANS = 2'b11;
        bus.HBUSREQ = 3'b110;
        tick();
        frozen = obs;
        bus.HREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.HBUSREQ = 3'($urandom_range(0, 7));
            bus.HLOCK   = 3'($urandom_range(0, 7));
            bus.HRESP   = 2'($urandom_range(0, 3));
            tick();
            nchk++;
            if (obs !== expv || obs !== frozen) begin
                nfail++;
                $display("FAIL wait cyc %0d: got %b want %b", k, obs, expv);
            end
        end
        bus.HREADY = 1'b1;
        bus.HRESP  = 2'b00;
        for (int k = 0; k < 2; k++) begin
            tick();
            nchk++;
            if (obs !== expv) begin
                nfail++;
                $display("FAIL wait_resume cyc %0d: got %b want %b", k, obs, expv);
            end
        end
    endtask

    task automatic test_retry();
        grant_to(1);
        bus.HBUSREQ = 3'b011;
        bus.HRESP   = 2'b10;
        tick();
        nchk++;
        if (bus.HGRANT !== 3'b001 || obs !== expv) begin
            nfail++;
            $display("FAIL retry_move: got %b want %b", obs, expv);
        end
        grant_to(1);
        bus.HBUSREQ = 3'b011;
        bus.HLOCK   = 3'b010;
        bus.HRESP   = 2'b10;
        tick();
        nchk++;
        if (bus.HGRANT !== 3'b010 || obs !== expv) begin
            nfail++;
            $display("FAIL retry_locked: got %b want %b", obs, expv);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bus.HBUSREQ = 3'($urandom_range(0, 7));
            bus.HLOCK   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            bus.HTRANS  = 2'($urandom_range(0, 3));
            bus.HREADY  = ($urandom_range(0, 3) != 0);
            bus.HRESP   = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'($urandom_range(0, 1) * 3);
            tick();
            nchk++;
            if (obs !== expv) begin
                nfail++;
                $display("FAIL random cyc %0d: got %b want %b", k, obs, expv);
            end
        end
    endtask

    task automatic test_reset_mid();
        grant_to(0);
        bus.HTRANS = 2'b11;
        bus.HLOCK  = 3'b001;
        tick(); tick();
        #2;
        rst = 1;
        #1;
        model_reset();
        nchk++;
        if (obs !== 6'b100_10_0 || obs !== expv) begin
            nfail++;
            $display("FAIL reset_mid: got %b want %b", obs, 6'b100_10_0);
        end
        idle_inputs();
        @(posedge clk); #1;
        rst = 0;
        bus.HBUSREQ = 3'b001;
        for (int k = 0; k < 2; k++) begin
            tick();
            nchk++;
            if (obs !== expv) begin
                nfail++;
                $display("FAIL reset_recover cyc %0d: got %b want %b", k, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_park_grant();
        test_burst();
        test_lock();
        test_wait_states();
        test_retry();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
